// File: rtl/alarm_bank_editor.sv
// alarm_bank_editor - multi-slot alarm store with a cursor-driven digit editor and second-tick match.
// Revision 1.0
`default_nettype none

module alarm_bank_editor #(
  parameter int         NUM_ALARMS = 4,
  parameter logic [3:0] MODE_CODE  = 4'b0101,
  parameter bit         HOUR_24    = 1'b0,
  parameter int         SW         = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    mode,
  input  logic [3:0]    num_sync,
  input  logic          sec_tick,
  input  logic          cur_meridiem,
  input  logic [6:0]    cur_hour,
  input  logic [6:0]    cur_min,
  input  logic [6:0]    cur_sec,
  output logic [3:0]    cursor,
  output logic [SW-1:0] slot,
  output logic          meridiem,
  output logic [6:0]    hour,
  output logic [6:0]    min,
  output logic [6:0]    sec,
  output logic          alm_en,
  output logic          alarm_hit,
  output logic [SW-1:0] alarm_idx
);

  typedef struct packed {
    logic       en;
    logic       mer;
    logic [6:0] hour;
    logic [6:0] min;
    logic [6:0] sec;
  } alarm_t;

  typedef enum logic [0:0] {IDLE = 1'b0, EDIT = 1'b1} state_t;

  localparam logic [6:0]    HMAX = HOUR_24 ? 7'd23 : 7'd11;
  localparam logic [SW-1:0] LAST = SW'(NUM_ALARMS - 1);

  state_t        state, state_nx;
  alarm_t        bank [NUM_ALARMS];
  alarm_t        shadow, shadow_nx, slot_rd, step_rd;
  logic [3:0]    cursor_nx;
  logic [SW-1:0] slot_nx, slot_step, hit_sel;
  logic          enter, leave, active, bank_we, hit_any, cur_mer;
  logic          inc, dec, rt, lt, do_edit, do_move, hit_now;

  // Minute/second digit editing; values stay within 0..59.
  function automatic logic [6:0] edit_ms(input logic [6:0] v, input logic tens, input logic up);
    logic [6:0] u, t10;
    u   = v % 7'd10;
    t10 = v - u;
    if (!tens) begin
      if (up) return (u == 7'd9) ? t10 : v + 7'd1;
      return (u == 7'd0) ? t10 + 7'd9 : v - 7'd1;
    end
    if (up) return (t10 >= 7'd50) ? u : v + 7'd10;
    return (t10 == 7'd0) ? u + 7'd50 : v - 7'd10;
  endfunction

  function automatic logic [6:0] edit_hr(input logic [6:0] v, input logic tens, input logic up);
    logic [6:0] u, t10, lo;
    u   = v % 7'd10;
    t10 = v - u;
    lo  = t10 + 7'd9;
    if (!tens) begin
      if (up) return (u == 7'd9 || v == HMAX) ? t10 : v + 7'd1;
      return (u == 7'd0) ? ((lo > HMAX) ? HMAX : lo) : v - 7'd1;
    end
    if (up) return (v + 7'd10 <= HMAX) ? v + 7'd10 : u;
    if (t10 != 7'd0) return v - 7'd10;
    // Tens is zero here, so u equals v: pick the largest reachable tens value.
    if (u + 7'd20 <= HMAX) return u + 7'd20;
    if (u + 7'd10 <= HMAX) return u + 7'd10;
    return v;
  endfunction

  assign inc     = num_sync[0];
  assign dec     = num_sync[1];
  assign rt      = num_sync[2];
  assign lt      = num_sync[3];
  assign do_edit = active && (inc ^ dec);
  assign do_move = active && (rt ^ lt);
  assign cur_mer = HOUR_24 ? 1'b0 : cur_meridiem;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    enter    = 1'b0;
    leave    = 1'b0;
    active   = 1'b0;
    case (state)
      IDLE: begin
        if (mode == MODE_CODE) begin
          state_nx = EDIT;
          enter    = 1'b1;
        end
      end
      EDIT: begin
        if (mode != MODE_CODE) begin
          state_nx = IDLE;
          leave    = 1'b1;
        end else begin
          active = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    if (inc) slot_step = (slot == LAST) ? '0 : slot + 1'b1;
    else     slot_step = (slot == '0) ? LAST : slot - 1'b1;
  end

  always_comb begin
    slot_rd = '0;
    step_rd = '0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      if (slot == SW'(i))      slot_rd = bank[i];
      if (slot_step == SW'(i)) step_rd = bank[i];
    end
  end

  always_comb begin
    shadow_nx = shadow;
    slot_nx   = slot;
    bank_we   = 1'b0;
    if (enter) begin
      shadow_nx = slot_rd;
    end else if (leave) begin
      bank_we = 1'b1;
    end else if (do_edit) begin
      case (cursor)
        4'd0: shadow_nx.sec  = edit_ms(shadow.sec, 1'b0, inc);
        4'd1: shadow_nx.sec  = edit_ms(shadow.sec, 1'b1, inc);
        4'd2: shadow_nx.min  = edit_ms(shadow.min, 1'b0, inc);
        4'd3: shadow_nx.min  = edit_ms(shadow.min, 1'b1, inc);
        4'd4: shadow_nx.hour = edit_hr(shadow.hour, 1'b0, inc);
        4'd5: shadow_nx.hour = edit_hr(shadow.hour, 1'b1, inc);
        4'd6: if (!HOUR_24) shadow_nx.mer = ~shadow.mer;
        4'd7: shadow_nx.en   = ~shadow.en;
        4'd8: begin
          bank_we = 1'b1;
          slot_nx = slot_step;
          // With a single slot the reload would fetch stale data, so keep the shadow.
          if (slot_step != slot) shadow_nx = step_rd;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cursor_nx = cursor;
    if (do_move) begin
      if (rt) cursor_nx = (cursor >= 4'd8) ? 4'd0 : cursor + 4'd1;
      else    cursor_nx = (cursor == 4'd0) ? 4'd8 : cursor - 4'd1;
      if (HOUR_24 && cursor_nx == 4'd6) cursor_nx = rt ? 4'd7 : 4'd5;
    end
  end

  // Scan downward so the lowest matching index wins.
  always_comb begin
    hit_any = 1'b0;
    hit_sel = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (bank[i].en && bank[i].mer == cur_mer && bank[i].hour == cur_hour &&
          bank[i].min == cur_min && bank[i].sec == cur_sec) begin
        hit_any = 1'b1;
        hit_sel = SW'(i);
      end
    end
  end

  assign hit_now = sec_tick && (state == IDLE) && hit_any;

  always_ff @(posedge clk) begin
    if (reset) begin
      cursor    <= 4'd0;
      slot      <= '0;
      shadow    <= '0;
      alarm_hit <= 1'b0;
      alarm_idx <= '0;
      for (int i = 0; i < NUM_ALARMS; i++) bank[i] <= '0;
    end else begin
      cursor    <= cursor_nx;
      slot      <= slot_nx;
      shadow    <= shadow_nx;
      alarm_hit <= hit_now;
      if (hit_now) alarm_idx <= hit_sel;
      for (int i = 0; i < NUM_ALARMS; i++) begin
        if (bank_we && slot == SW'(i)) bank[i] <= shadow;
      end
    end
  end

  assign meridiem = shadow.mer;
  assign hour     = shadow.hour;
  assign min      = shadow.min;
  assign sec      = shadow.sec;
  assign alm_en   = shadow.en;

endmodule

`default_nettype wire

// File: tb/tb_alarm_bank_editor.sv
// tb_alarm_bank_editor - directed checks of the alarm editor in 12h and 24h configurations.
// Revision 1.0
`default_nettype none

module tb_alarm_bank_editor;

  localparam logic [3:0] INC = 4'b0001;
  localparam logic [3:0] DEC = 4'b0010;
  localparam logic [3:0] RT  = 4'b0100;
  localparam logic [3:0] LT  = 4'b1000;
  localparam logic [3:0] MC  = 4'b0101;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] mode = 4'd0;
  logic [3:0] mode24 = 4'd0;
  logic [3:0] num_sync = 4'd0;
  logic       sec_tick = 1'b0;
  logic       cur_meridiem = 1'b0;
  logic [6:0] cur_hour = 7'd0, cur_min = 7'd0, cur_sec = 7'd0;

  logic [3:0] cursor, cursor24;
  logic [2:0] slot, slot24, alarm_idx, alarm_idx24;
  logic       meridiem, meridiem24, alm_en, alm_en24, alarm_hit, alarm_hit24;
  logic [6:0] hour, min, sec, hour24, min24, sec24;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alarm_bank_editor #(.NUM_ALARMS(4), .MODE_CODE(MC), .HOUR_24(1'b0), .SW(3)) dut (
    .clk(clk), .reset(reset), .mode(mode), .num_sync(num_sync), .sec_tick(sec_tick),
    .cur_meridiem(cur_meridiem), .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
    .cursor(cursor), .slot(slot), .meridiem(meridiem), .hour(hour), .min(min), .sec(sec),
    .alm_en(alm_en), .alarm_hit(alarm_hit), .alarm_idx(alarm_idx)
  );

  alarm_bank_editor #(.NUM_ALARMS(4), .MODE_CODE(MC), .HOUR_24(1'b1), .SW(3)) dut24 (
    .clk(clk), .reset(reset), .mode(mode24), .num_sync(num_sync), .sec_tick(sec_tick),
    .cur_meridiem(cur_meridiem), .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
    .cursor(cursor24), .slot(slot24), .meridiem(meridiem24), .hour(hour24), .min(min24),
    .sec(sec24), .alm_en(alm_en24), .alarm_hit(alarm_hit24), .alarm_idx(alarm_idx24)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic keys(input logic [3:0] k);
    num_sync = k;
    step();
    num_sync = 4'd0;
  endtask

  task automatic press(input logic [3:0] k, input int n);
    for (int i = 0; i < n; i++) keys(k);
  endtask

  task automatic tick();
    sec_tick = 1'b1;
    step();
    sec_tick = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    step();
    step();
    reset = 1'b0;
    step();
    chk("rst_cursor", cursor, 0);
    chk("rst_slot", slot, 0);
    chk("rst_sec", sec, 0);
    chk("rst_hour", hour, 0);
    chk("rst_en", alm_en, 0);
    chk("rst_hit", alarm_hit, 0);
    chk("rst_idx", alarm_idx, 0);

    // Enter EDIT on both instances.
    mode = MC;
    mode24 = MC;
    step();
    chk("entry_cursor", cursor, 0);
    chk("entry_slot", slot, 0);
    chk("entry_min", min, 0);
    chk("entry_en", alm_en, 0);
    keys(LT);
    chk("left_wrap", cursor, 8);
    chk("left_wrap24", cursor24, 8);
    keys(RT);
    chk("right_wrap", cursor, 0);

    // Seconds digit wrapping.
    keys(DEC);
    chk("sec_u_dec0", sec, 9);
    keys(RT);
    keys(DEC);
    chk("sec_t_dec0", sec, 59);
    keys(LT);
    keys(INC);
    chk("sec_u_inc9", sec, 50);
    keys(RT);
    keys(INC);
    chk("sec_t_inc5", sec, 0);
    keys(DEC);
    chk("sec_t_dec_from0", sec, 50);

    // Hours in both modes.
    press(RT, 3);
    keys(DEC);
    chk("hr_u_dec0", hour, 9);
    chk("hr_u_dec0_24", hour24, 9);
    keys(RT);
    keys(INC);
    chk("hr_t_inc_over", hour, 9);
    chk("hr_t_inc_24", hour24, 19);
    keys(INC);
    chk("hr_t_inc19_24", hour24, 9);
    keys(LT);
    press(INC, 2);
    keys(RT);
    keys(INC);
    chk("hr_set11", hour, 11);
    keys(LT);
    keys(INC);
    chk("hr_u_inc_max", hour, 10);
    chk("hr_u_inc11_24", hour24, 12);
    keys(RT);
    keys(DEC);
    chk("hr_t_dec10", hour, 0);
    chk("hr_t_dec12_24", hour24, 2);
    keys(LT);
    press(INC, 2);
    keys(RT);
    keys(DEC);
    chk("hr_t_dec2", hour, 2);
    chk("hr_t_dec4_24", hour24, 14);

    // Position 6 skipped only in 24h mode.
    keys(RT);
    chk("cur_to6", cursor, 6);
    chk("cur_skip6_r", cursor24, 7);
    keys(LT);
    chk("cur_skip6_l", cursor24, 5);
    mode24 = 4'd0;
    step();

    // Slot 0: PM 07:30:15 enabled.
    keys(LT);
    press(INC, 5);
    press(LT, 3);
    press(DEC, 4);
    keys(LT);
    press(INC, 5);
    press(RT, 3);
    press(INC, 3);
    press(RT, 3);
    keys(INC);
    keys(RT);
    keys(INC);
    keys(RT);
    chk("s0_hour", hour, 7);
    chk("s0_min", min, 30);
    chk("s0_sec", sec, 15);
    chk("s0_mer", meridiem, 1);
    chk("s0_en", alm_en, 1);
    keys(INC);
    chk("s1_slot", slot, 1);
    chk("s1_hour", hour, 0);
    chk("s1_en", alm_en, 0);
    keys(DEC);
    chk("back_slot", slot, 0);
    chk("back_hour", hour, 7);
    chk("back_min", min, 30);
    chk("back_sec", sec, 15);
    chk("back_mer", meridiem, 1);
    chk("back_en", alm_en, 1);

    mode = 4'd0;
    step();
    cur_meridiem = 1'b1;
    cur_hour = 7'd7;
    cur_min = 7'd30;
    cur_sec = 7'd15;
    tick();
    chk("hit0", alarm_hit, 1);
    chk("hit0_idx", alarm_idx, 0);
    step();
    chk("hit0_pulse", alarm_hit, 0);
    cur_sec = 7'd16;
    tick();
    chk("nomatch_hit", alarm_hit, 0);
    chk("nomatch_idx", alarm_idx, 0);

    // Slots 1 and 3: AM 00:00:05 enabled.
    mode = MC;
    step();
    keys(INC);
    keys(RT);
    press(INC, 5);
    press(LT, 2);
    keys(INC);
    keys(RT);
    press(INC, 2);
    keys(LT);
    keys(INC);
    press(LT, 7);
    press(INC, 5);
    chk("s3_slot", slot, 3);
    chk("s3_sec", sec, 5);
    mode = 4'd0;
    step();
    cur_meridiem = 1'b0;
    cur_hour = 7'd0;
    cur_min = 7'd0;
    cur_sec = 7'd5;
    tick();
    chk("prio_hit", alarm_hit, 1);
    chk("prio_idx", alarm_idx, 1);
    mode = MC;
    step();
    tick();
    chk("edit_tick_hit", alarm_hit, 0);
    chk("edit_tick_idx", alarm_idx, 1);

    // Conflicting keys and pre-move cursor for edits.
    keys(INC | DEC);
    chk("incdec_sec", sec, 5);
    keys(RT | LT);
    chk("rtlt_cursor", cursor, 0);
    keys(INC | RT);
    chk("edit_premove_sec", sec, 6);
    chk("edit_premove_cur", cursor, 1);

    // Reset mid-edit discards everything.
    reset = 1'b1;
    mode = 4'd0;
    step();
    chk("mid_rst_cursor", cursor, 0);
    chk("mid_rst_slot", slot, 0);
    chk("mid_rst_sec", sec, 0);
    chk("mid_rst_en", alm_en, 0);
    chk("mid_rst_idx", alarm_idx, 0);
    reset = 1'b0;
    step();
    tick();
    chk("post_rst_hit", alarm_hit, 0);
    mode = MC;
    step();
    chk("post_rst_shadow", sec, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
